// File: rtl/vga_face_pkg.sv
// Shared types and constants for the VGA face scheduler and stream source.
// Face codes, filter codes and frame geometry live here.
package vga_face_pkg;

  typedef enum logic [1:0] {
    FACE_WOLF  = 2'd0,
    FACE_P2    = 2'd1,
    FACE_TROLL = 2'd2,
    FACE_KEEP  = 2'd3
  } face_t;

  typedef logic [3:0] filter_t;

  localparam filter_t FILT_NONE    = 4'b0000;
  localparam filter_t FILT_INVERT  = 4'b0001;
  localparam filter_t FILT_LIGHTEN = 4'b0010;
  localparam filter_t FILT_DARKEN  = 4'b0100;
  localparam filter_t FILT_GREY    = 4'b1000;
  localparam filter_t FILT_BLUR    = 4'b1111;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  function automatic logic filter_legal(filter_t f);
    case (f)
      FILT_NONE, FILT_INVERT, FILT_LIGHTEN,
      FILT_DARKEN, FILT_GREY, FILT_BLUR:
        filter_legal = 1'b1;
      default:
        filter_legal = 1'b0;
    endcase
  endfunction

  function automatic filter_t filter_sanitize(filter_t f);
    filter_sanitize = filter_legal(f) ? f : FILT_NONE;
  endfunction

  // Auto-cycle order: wolf -> p2 -> troll -> wolf
  function automatic face_t face_next(face_t f);
    case (f)
      FACE_WOLF: face_next = FACE_P2;
      FACE_P2:   face_next = FACE_TROLL;
      default:   face_next = FACE_WOLF;
    endcase
  endfunction

endpackage

// File: rtl/vga_face_if.sv
// Command requesters and monitored Avalon-ST handshake of the face source.
// The scheduler is the slave; requesters and the stream are the master.
interface vga_face_if;
  import vga_face_pkg::*;

  logic [1:0] req_valid;
  logic [3:0] req_face;
  logic [7:0] req_filter;
  logic [1:0] req_ready;
  logic       st_valid;
  logic       st_ready;
  logic       st_eop;

  modport master (
    output req_valid, req_face, req_filter,
    output st_valid, st_ready, st_eop,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_face, req_filter,
    input  st_valid, st_ready, st_eop,
    output req_ready
  );

endinterface

// File: rtl/vga_face_rr_arb.sv
// Two-input round-robin arbiter; on a tie the side not granted last wins.
// Pointer resets so that requester 0 is preferred.
module vga_face_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (|req)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/vga_face_scheduler.sv
// Frame-synchronous face/filter scheduler: arbitrates commands and
// applies them only on stream frame-end beats, then holds them.
module vga_face_scheduler
  import vga_face_pkg::*;
#(
  parameter int MIN_HOLD_FRAMES   = 30,
  parameter int AUTO_CYCLE_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  vga_face_if.slave   bus,
  input  logic        auto_en,
  output logic [1:0]  face_select,
  output logic [3:0]  filter_select,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [7:0]  hold_cnt;
  logic [15:0] idle_frames;
  face_t       pend_face;
  filter_t     pend_filter;
  logic [1:0]  grant;
  logic        fe;
  logic        take_req;
  logic        take_auto;
  face_t       req_face_sel;
  filter_t     req_filt_sel;

  assign fe = bus.st_valid & bus.st_ready & bus.st_eop;

  assign take_req = (state == S_IDLE) & (|bus.req_valid);

  assign take_auto = (state == S_IDLE) & ~(|bus.req_valid)
                   & auto_en
                   & (idle_frames == 16'(AUTO_CYCLE_FRAMES));

  assign req_face_sel = grant[1] ? face_t'(bus.req_face[3:2])
                                 : face_t'(bus.req_face[1:0]);

  assign req_filt_sel = grant[1] ? bus.req_filter[7:4]
                                 : bus.req_filter[3:0];

  assign busy = (state != S_IDLE);

  vga_face_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .advance (take_req),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      hold_cnt      <= 8'd0;
      idle_frames   <= 16'd0;
      pend_face     <= FACE_WOLF;
      pend_filter   <= FILT_NONE;
      face_select   <= 2'd0;
      filter_select <= 4'd0;
      frame_count   <= 16'd0;
      bus.req_ready <= 2'b00;
    end else begin
      bus.req_ready <= take_req ? grant : 2'b00;
      if (fe) begin
        frame_count <= frame_count + 16'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (take_req) begin
            pend_face   <= req_face_sel;
            pend_filter <= filter_sanitize(req_filt_sel);
            idle_frames <= 16'd0;
            state       <= S_PEND;
          end else if (take_auto) begin
            pend_face   <= face_next(face_t'(face_select));
            pend_filter <= filter_select;
            idle_frames <= 16'd0;
            state       <= S_PEND;
          end else if (!auto_en) begin
            idle_frames <= 16'd0;
          end else if (fe) begin
            idle_frames <= idle_frames + 16'd1;
          end
        end
        S_PEND: begin
          idle_frames <= 16'd0;
          if (fe) begin
            // Keep code resolves against the face on screen right now
            face_select   <= (pend_face == FACE_KEEP) ? face_select
                                                      : pend_face;
            filter_select <= pend_filter;
            hold_cnt      <= 8'(MIN_HOLD_FRAMES);
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          idle_frames <= 16'd0;
          if (fe) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt == 8'd1) begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_face_scheduler.md
# vga_face_scheduler

Frame-synchronous controller for the VGA face stream source. Arbitrates face/filter change commands from two requesters (game FSM, audio classifier) and provides an optional auto-cycle mode. Drives the source's `face_select` and `filter_select` so that every change lands exactly on a frame boundary. Passively monitors the source's Avalon-ST handshake and never stalls it.

## Interface

Parameters:
- `MIN_HOLD_FRAMES`, default 30: number of completed frames an applied setting is held before a new command may be accepted; legal range 1..255.
- `AUTO_CYCLE_FRAMES`, default 120: number of idle frames before an auto face advance; legal range 1..65535.

Ports (reset is synchronous, active-high; clock is `clk`):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 2: requester i has a pending command; held until accepted.
- `req_face`, in, 4: requester i's face code, in bits [2i+1:2i].
- `req_filter`, in, 8: requester i's filter code, in bits [4i+3:4i].
- `req_ready`, out, 2: one-hot, one-cycle accept pulse.
- `auto_en`, in, 1: enables auto-cycle.
- `st_valid`, `st_ready`, `st_eop`, in, 1 each: monitored stream handshake.
- `face_select`, out, 2: face code to the source.
- `filter_select`, out, 4: filter code to the source.
- `frame_count`, out, 16: count of completed frames.
- `busy`, out, 1: high when the scheduler is not in IDLE.

## Operation

- The frame end event is `fe = st_valid & st_ready & st_eop`.
- FSM states are IDLE, PENDING and HOLD. Reset enters IDLE.
- **IDLE**
  - If any `req_valid` is set, grant one requester. Pulse its `req_ready` bit, latch its face and filter into the pending registers, and go to PENDING.
  - Arbitration is round-robin. On simultaneous requests, grant the requester not granted last. After reset, requester 0 is preferred.
- **Auto-cycle (in IDLE)**
  - When `auto_en` is high and no request is present, `idle_frames` counts fe events.
  - When `idle_frames` reaches `AUTO_CYCLE_FRAMES`, form an internal command and go to PENDING. Face advances 0→1→2→0; filter is unchanged.
  - A request present in the same cycle wins over the auto command.
  - `idle_frames` clears whenever the FSM leaves IDLE or `auto_en` is low.
- **PENDING**
  - On fe, copy the pending registers to the outputs.
  - Load `hold_cnt` with `MIN_HOLD_FRAMES` and go to HOLD.
- **HOLD**
  - Each fe decrements `hold_cnt`.
  - On the fe that takes `hold_cnt` from 1 to 0, go to IDLE.
  - Requests are not accepted in this state; they stay pending at the requester.
- **Code sanitising (applied at latch time)**
  - Face code 3 means "keep current face", for filter-only changes. It resolves to the `face_select` value at apply time.
  - Legal filter codes are 0000, 0001, 0010, 0100, 1000 and 1111. Any other code is replaced with 0000.
- `frame_count` increments on every fe in any state and wraps from 65535 to 0.

## Timing

- Reset values:
  - `face_select` = 0 and `filter_select` = 0.
  - `req_ready` = 00, `busy` = 0, `frame_count` = 0.
  - `hold_cnt` = 0, `idle_frames` = 0, and the arbiter pointer prefers requester 0.
- Reset during PENDING or HOLD discards the pending command and does not pulse `req_ready`.
- `req_ready` is registered. It is high in the cycle after IDLE samples `req_valid`, and the FSM is in PENDING in that same cycle. Requesters drop `req_valid` the cycle after seeing `req_ready`.
- Output update:
  - `face_select` and `filter_select` are registered.
  - They change on the clock edge that samples fe, so the next sop beat already sees the new values.
  - They never change except on an fe edge or reset.
- Minimum command-to-command spacing is `MIN_HOLD_FRAMES` frames after apply.
- When fe and a request coincide in IDLE, the request is accepted. That fe only counts toward `frame_count`; the command applies at the following fe.
- When fe and the hold_cnt 1→0 transition coincide, a request can be accepted at the earliest on the next cycle.
- `busy` is high in PENDING and HOLD.

## Structure

- Shared package `vga_face_pkg` holds:
  - the `face_t` enum (Wolf=0, P2=1, Troll=2, Keep=3);
  - the `filter_t` localparams (NONE, INVERT, LIGHTEN, DARKEN, GREY, BLUR);
  - a `filter_legal()` function;
  - the frame geometry constants shared with the source.
- Sub-module `vga_face_rr_arb` is a 2-input round-robin arbiter with inputs req[1:0] and advance, output grant one-hot, and an internal last-grant pointer.

## Test plan

1. Reset, then requester 0 sends face=2, filter=0001, with `MIN_HOLD_FRAMES`=2 → `req_ready`=01 one cycle later. Outputs stay at 0/0 until the first fe, then become 2/0001. `busy` drops after 2 further fe events.
2. Both requesters assert together three times → grants are 01, 10, 01. Each grant waits for its hold to expire.
3. Request with face=3 and filter=0011 while `face_select`=1 → after fe, outputs are 1/0000.
4. `auto_en`=1, `AUTO_CYCLE_FRAMES`=3, no requests → face sequence 0→1→2→0, advancing every 3+1+`MIN_HOLD_FRAMES` fe events. `filter_select` is unchanged throughout.
5. Request accepted, then `reset` asserted in PENDING before fe → outputs are 0/0, `busy`=0, no apply at the next fe.
6. 65536 fe pulses → `frame_count` wraps to 0. `st_eop` with `st_ready`=0 causes no count and no apply.
